axi4lite_max7219: RTL and testbench



---
 rtl/axi4lite_max7219.sv | 247 ++++++++++++++++++++++++
 tb/tb_axi4lite_max7219.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_max7219.sv
// AXI4-Lite slave that serializes a frame buffer into a chain of MAX7219 drivers.
// Frames leave farthest-matrix first, MSB first; one LOAD pulse latches the whole chain.
module axi4lite_max7219 #(
   parameter int G_AXI4_LITE_ADDR_WIDTH = 8,
   parameter int G_AXI4_LITE_DATA_WIDTH = 32,
   parameter int G_MATRIX_NB            = 4
) (
   input  logic                              clk_sys,
   input  logic                              rst_n_sys,
   input  logic                              awvalid,
   output logic                              awready,
   input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0] awaddr,
   input  logic [2:0]                        awprot,
   input  logic                              wvalid,
   output logic                              wready,
   input  logic [G_AXI4_LITE_DATA_WIDTH-1:0] wdata,
   input  logic [3:0]                        wstrb,
   output logic                              bvalid,
   input  logic                              bready,
   output logic [1:0]                        bresp,
   input  logic                              arvalid,
   output logic                              arready,
   input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0] araddr,
   input  logic [2:0]                        arprot,
   output logic                              rvalid,
   input  logic                              rready,
   output logic [G_AXI4_LITE_DATA_WIDTH-1:0] rdata,
   output logic [1:0]                        rresp,
   output logic                              o_max7219_clk,
   output logic                              o_max7219_data,
   output logic                              o_max7219_load
);

   localparam int             BITS       = G_MATRIX_NB * 16;
   localparam int             BW         = $clog2(BITS);
   localparam logic [BW-1:0]  LAST_BIT   = BW'(BITS - 1);
   localparam logic [5:0]     FRAME_BASE = 6'd4;
   localparam logic [5:0]     FRAME_END  = 6'(4 + G_MATRIX_NB);
   localparam logic [1:0]     RESP_OKAY  = 2'b00;
   localparam logic [1:0]     RESP_SLV   = 2'b10;

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT_LOW, ST_SHIFT_HIGH, ST_LOAD} state_t;

   // AXI channel registers
   logic        aw_w_ready_reg;
   logic        bvalid_reg;
   logic [1:0]  bresp_reg;
   logic        arready_reg;
   logic        rvalid_reg;
   logic [31:0] rdata_reg;
   logic [1:0]  rresp_reg;

   // register file
   logic [7:0]      clkdiv_reg;
   logic            done_reg;
   logic [BITS-1:0] frames_flat;

   // serializer
   state_t          state_reg;
   logic [BITS-1:0] shift_reg;
   logic [BW-1:0]   bit_cnt_reg;
   logic [7:0]      div_reg;
   logic [7:0]      cnt_reg;
   logic            sclk_reg;
   logic            din_reg;
   logic            load_reg;

   logic [5:0]  wr_idx;
   logic [5:0]  rd_idx;
   logic [5:0]  wr_fidx;
   logic [5:0]  rd_fidx;
   logic        wr_en;
   logic        rd_en;
   logic        wr_frame_hit;
   logic        rd_frame_hit;
   logic        wr_mapped;
   logic        start_req;
   logic        done_clr;
   logic        busy;
   logic        phase_end;
   logic [15:0] rd_frame;
   logic [31:0] rd_data_next;
   logic [1:0]  rd_resp_next;
   logic        unused_bits;

   assign unused_bits = ^{awprot, arprot, awaddr[1:0], araddr[1:0], wdata[31:16], wstrb[3:2]};

   assign wr_idx       = awaddr[7:2];
   assign rd_idx       = araddr[7:2];
   assign wr_fidx      = wr_idx - FRAME_BASE;
   assign rd_fidx      = rd_idx - FRAME_BASE;
   assign wr_en        = aw_w_ready_reg && awvalid && wvalid;
   assign rd_en        = arready_reg && arvalid;
   assign wr_frame_hit = (wr_idx >= FRAME_BASE) && (wr_idx < FRAME_END);
   assign rd_frame_hit = (rd_idx >= FRAME_BASE) && (rd_idx < FRAME_END);
   assign wr_mapped    = (wr_idx <= 6'd2) || wr_frame_hit;
   assign start_req    = wr_en && (wr_idx == 6'd0) && wstrb[0] && wdata[0];
   assign done_clr     = wr_en && (wr_idx == 6'd1) && wstrb[0] && wdata[1];
   assign busy         = (state_reg != ST_IDLE);
   assign phase_end    = (cnt_reg == div_reg - 8'd1);

   assign awready        = aw_w_ready_reg;
   assign wready         = aw_w_ready_reg;
   assign bvalid         = bvalid_reg;
   assign bresp          = bresp_reg;
   assign arready        = arready_reg;
   assign rvalid         = rvalid_reg;
   assign rdata          = rdata_reg;
   assign rresp          = rresp_reg;
   assign o_max7219_clk  = sclk_reg;
   assign o_max7219_data = din_reg;
   assign o_max7219_load = load_reg;

   // FRAME[gi] occupies frames_flat[gi*16 +: 16], so the farthest matrix lands in the MSBs
   generate
      for (genvar gi = 0; gi < G_MATRIX_NB; gi++) begin : g_frame
         logic [15:0] frame_reg;
         always_ff @(posedge clk_sys or negedge rst_n_sys) begin
            if (!rst_n_sys) begin
               frame_reg <= '0;
            end else if (wr_en && wr_frame_hit && (wr_fidx == 6'(gi))) begin
               if (wstrb[0]) frame_reg[7:0]  <= wdata[7:0];
               if (wstrb[1]) frame_reg[15:8] <= wdata[15:8];
            end
         end
         assign frames_flat[gi*16 +: 16] = frame_reg;
      end
   endgenerate

   always_ff @(posedge clk_sys or negedge rst_n_sys) begin
      if (!rst_n_sys) begin
         aw_w_ready_reg <= 1'b0;
         bvalid_reg     <= 1'b0;
         bresp_reg      <= RESP_OKAY;
         clkdiv_reg     <= 8'd4;
      end else begin
         // the !aw_w_ready_reg term keeps the ready a single-cycle pulse
         aw_w_ready_reg <= awvalid && wvalid && !bvalid_reg && !aw_w_ready_reg;
         if (wr_en) begin
            bvalid_reg <= 1'b1;
            bresp_reg  <= wr_mapped ? RESP_OKAY : RESP_SLV;
         end else if (bready) begin
            bvalid_reg <= 1'b0;
         end
         if (wr_en && (wr_idx == 6'd2) && wstrb[0]) clkdiv_reg <= wdata[7:0];
      end
   end

   always_comb begin
      rd_frame = '0;
      for (int i = 0; i < G_MATRIX_NB; i++) begin
         if (rd_fidx == 6'(i)) rd_frame = frames_flat[i*16 +: 16];
      end
      rd_data_next = '0;
      rd_resp_next = RESP_OKAY;
      if (rd_idx == 6'd1)       rd_data_next = {30'd0, done_reg, busy};
      else if (rd_idx == 6'd2)  rd_data_next = {24'd0, clkdiv_reg};
      else if (rd_frame_hit)    rd_data_next = {16'd0, rd_frame};
      else if (rd_idx != 6'd0)  rd_resp_next = RESP_SLV;
   end

   always_ff @(posedge clk_sys or negedge rst_n_sys) begin
      if (!rst_n_sys) begin
         arready_reg <= 1'b0;
         rvalid_reg  <= 1'b0;
         rdata_reg   <= '0;
         rresp_reg   <= RESP_OKAY;
      end else begin
         arready_reg <= arvalid && !rvalid_reg && !arready_reg;
         if (rd_en) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_data_next;
            rresp_reg  <= rd_resp_next;
         end else if (rready) begin
            rvalid_reg <= 1'b0;
         end
      end
   end

   // the first bit goes straight to DIN, shift_reg holds the remainder
   always_ff @(posedge clk_sys or negedge rst_n_sys) begin
      if (!rst_n_sys) begin
         state_reg   <= ST_IDLE;
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         div_reg     <= 8'd1;
         cnt_reg     <= '0;
         sclk_reg    <= 1'b0;
         din_reg     <= 1'b0;
         load_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         if (done_clr) done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start_req) begin
                  state_reg   <= ST_SHIFT_LOW;
                  din_reg     <= frames_flat[BITS-1];
                  shift_reg   <= {frames_flat[BITS-2:0], 1'b0};
                  bit_cnt_reg <= '0;
                  cnt_reg     <= '0;
                  div_reg     <= (clkdiv_reg == 8'd0) ? 8'd1 : clkdiv_reg;
               end
            end
            ST_SHIFT_LOW: begin
               if (phase_end) begin
                  cnt_reg   <= '0;
                  sclk_reg  <= 1'b1;
                  state_reg <= ST_SHIFT_HIGH;
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            ST_SHIFT_HIGH: begin
               if (phase_end) begin
                  cnt_reg  <= '0;
                  sclk_reg <= 1'b0;
                  if (bit_cnt_reg == LAST_BIT) begin
                     din_reg   <= 1'b0;
                     load_reg  <= 1'b1;
                     state_reg <= ST_LOAD;
                  end else begin
                     din_reg     <= shift_reg[BITS-1];
                     shift_reg   <= {shift_reg[BITS-2:0], 1'b0};
                     bit_cnt_reg <= bit_cnt_reg + BW'(1);
                     state_reg   <= ST_SHIFT_LOW;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            ST_LOAD: begin
               if (phase_end) begin
                  cnt_reg   <= '0;
                  load_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= ST_IDLE;
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4lite_max7219.sv
// Bench for axi4lite_max7219: a cycle-indexed waveform model checks the pins every cycle,
// AXI responses are checked against a register model, literals pin the model.
module tb_axi4lite_max7219;

   localparam int NB = 4;

   logic        clk_sys = 1'b0;
   logic        rst_n_sys = 1'b0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
   logic [7:0]  awaddr = '0, araddr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic        o_max7219_clk, o_max7219_data, o_max7219_load;

   always #5 clk_sys = ~clk_sys;

   axi4lite_max7219 #(.G_AXI4_LITE_ADDR_WIDTH(8), .G_AXI4_LITE_DATA_WIDTH(32), .G_MATRIX_NB(NB)) dut (
      .clk_sys(clk_sys), .rst_n_sys(rst_n_sys),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(3'b000),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(3'b000),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .o_max7219_clk(o_max7219_clk), .o_max7219_data(o_max7219_data), .o_max7219_load(o_max7219_load)
   );

   int n_pass = 0, n_total = 0;
   int cyc = 0;

   // register and transfer model
   logic [15:0] m_frame [NB];
   logic [7:0]  m_div = 8'd4;
   logic        done_m = 1'b0;
   bit          m_active = 1'b0;
   int          xfer_cyc = 0, m_d = 1, m_total = 0, last_start_h = 0;
   logic        m_stream [NB*16];

   // pin monitor
   logic        prev_clk = 1'b0, prev_load = 1'b0;
   logic [15:0] rx_sh = '0;
   logic [15:0] rx_q [$];
   int          rx_bits = 0, load_cnt = 0, load_bits_at = 0, load_fall_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick();
      int t;
      logic ec, ed, el;
      @(negedge clk_sys);
      t  = cyc - xfer_cyc;
      ec = 1'b0; ed = 1'b0; el = 1'b0;
      if (m_active && t >= 0 && t < NB*32*m_d) begin
         ec = ((t % (2*m_d)) >= m_d);
         ed = m_stream[t / (2*m_d)];
      end else if (m_active && t >= NB*32*m_d && t < m_total) begin
         el = 1'b1;
      end
      if (m_active && t == m_total) done_m = 1'b1;
      chk("pins", {29'd0, o_max7219_clk, o_max7219_data, o_max7219_load}, {29'd0, ec, ed, el});
      if (o_max7219_clk && !prev_clk) begin
         rx_sh = {rx_sh[14:0], o_max7219_data};
         rx_bits++;
         if (rx_bits % 16 == 0) rx_q.push_back(rx_sh);
      end
      if (o_max7219_load && !prev_load) begin
         load_cnt++;
         load_bits_at = rx_bits;
      end
      if (!o_max7219_load && prev_load) load_fall_cyc = cyc;
      prev_clk  = o_max7219_clk;
      prev_load = o_max7219_load;
      @(posedge clk_sys);
      cyc++;
      #1;
   endtask

   task automatic clr_mon();
      rx_q.delete();
      rx_bits = 0; load_cnt = 0; load_bits_at = 0; rx_sh = '0;
   endtask

   task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                              input int h, output logic [1:0] resp);
      int idx, k;
      idx  = int'(a[7:2]);
      resp = 2'b00;
      if (idx == 0) begin
         if (s[0] && d[0] && !(m_active && (h - xfer_cyc) < m_total)) begin
            m_d     = (m_div == 8'd0) ? 1 : int'(m_div);
            m_total = NB*32*m_d + m_d;
            k = 0;
            for (int f = NB-1; f >= 0; f--)
               for (int b = 15; b >= 0; b--) begin
                  m_stream[k] = m_frame[f][b];
                  k++;
               end
            xfer_cyc     = h + 1;
            last_start_h = h;
            m_active     = 1'b1;
         end
      end else if (idx == 1) begin
         if (s[0] && d[1]) done_m = 1'b0;
      end else if (idx == 2) begin
         if (s[0]) m_div = d[7:0];
      end else if (idx >= 4 && idx < 4 + NB) begin
         if (s[0]) m_frame[idx-4][7:0]  = d[7:0];
         if (s[1]) m_frame[idx-4][15:8] = d[15:8];
      end else begin
         resp = 2'b10;
      end
   endtask

   task automatic model_read(input logic [7:0] a, input int h, output logic [31:0] d, output logic [1:0] resp);
      int idx;
      logic busy;
      idx  = int'(a[7:2]);
      busy = m_active && (h - xfer_cyc) >= 0 && (h - xfer_cyc) < m_total;
      d    = '0;
      resp = 2'b00;
      if (idx == 1)                        d = {30'd0, done_m, busy};
      else if (idx == 2)                   d = {24'd0, m_div};
      else if (idx >= 4 && idx < 4 + NB)   d = {16'd0, m_frame[idx-4]};
      else if (idx != 0)                   resp = 2'b10;
   endtask

   task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      logic [1:0] eresp;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!awready && n < 20);
      chk("awready", 32'(awready), 32'd1);
      chk("wready", 32'(wready), 32'd1);
      if (!awready) begin
         awvalid = 1'b0; wvalid = 1'b0;
         return;
      end
      model_write(a, d, s, cyc, eresp);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("bvalid", 32'(bvalid), 32'd1);
      chk("bresp", 32'(bresp), 32'(eresp));
      $display("WR addr=0x%02h data=0x%08h strb=%b bresp=%0d", a, d, s, bresp);
      tick();
      chk("bvalid_drop", 32'(bvalid), 32'd0);
   endtask

   task automatic axi_read(input logic [7:0] a, output logic [31:0] d);
      int n;
      logic [31:0] ed;
      logic [1:0]  er;
      araddr = a; arvalid = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!arready && n < 20);
      chk("arready", 32'(arready), 32'd1);
      d = '0;
      if (!arready) begin
         arvalid = 1'b0;
         return;
      end
      model_read(a, cyc, ed, er);
      tick();
      arvalid = 1'b0;
      chk("rvalid", 32'(rvalid), 32'd1);
      chk("rdata", rdata, ed);
      chk("rresp", 32'(rresp), 32'(er));
      d = rdata;
      $display("RD addr=0x%02h data=0x%08h rresp=%0d", a, rdata, rresp);
      tick();
      chk("rvalid_drop", 32'(rvalid), 32'd0);
   endtask

   task automatic do_reset();
      rst_n_sys = 1'b0;
      m_active  = 1'b0;
      done_m    = 1'b0;
      m_div     = 8'd4;
      for (int i = 0; i < NB; i++) m_frame[i] = '0;
      repeat (3) tick();
      rst_n_sys = 1'b1;
      tick();
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (m_active && (cyc - xfer_cyc) <= m_total && n < 5000) begin
         tick();
         n++;
      end
      repeat (2) tick();
   endtask

   logic [31:0] r;
   logic [15:0] exp_words [4] = '{16'h0F00, 16'h0900, 16'h0A0F, 16'h0C01};

   initial begin
      do_reset();
      chk("axi_reset", {24'd0, awready, wready, bvalid, arready, rvalid, bresp[1], rresp[1], |rdata}, 32'd0);
      axi_read(8'h04, r); chk("status_rst_lit", r, 32'h0);
      axi_read(8'h08, r); chk("clkdiv_rst_lit", r, 32'h4);

      // four frames at CLKDIV 4; FRAME and CLKDIV writes during the transfer must not leak in
      axi_write(8'h10, 32'h0C01, 4'hF);
      axi_write(8'h14, 32'h0A0F, 4'hF);
      axi_write(8'h18, 32'h0900, 4'hF);
      axi_write(8'h1C, 32'h0F00, 4'hF);
      clr_mon();
      axi_write(8'h00, 32'h1, 4'hF);
      axi_read(8'h04, r); chk("status_busy_lit", r, 32'h1);
      axi_write(8'h1C, 32'hFFFF, 4'h3);
      axi_write(8'h08, 32'h1, 4'h1);
      wait_idle();
      chk("rx_words", 32'(rx_q.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < rx_q.size()) chk("rx_word_lit", 32'(rx_q[i]), 32'(exp_words[i]));
      chk("load_count", 32'(load_cnt), 32'd1);
      chk("load_after_bits", 32'(load_bits_at), 32'd64);
      axi_read(8'h04, r); chk("status_done_lit", r, 32'h2);

      // CLKDIV 1, with a second START while busy
      axi_write(8'h1C, 32'h0F00, 4'h3);
      axi_write(8'h04, 32'h2, 4'h1);
      clr_mon();
      axi_write(8'h00, 32'h1, 4'h1);
      repeat (10) tick();
      axi_write(8'h00, 32'h1, 4'h1);
      wait_idle();
      chk("busy_len_div1", 32'(load_fall_cyc - (last_start_h + 1)), 32'd129);
      chk("clk_rises", 32'(rx_bits), 32'd64);
      chk("load_count2", 32'(load_cnt), 32'd1);

      // CLKDIV 0 behaves as 1
      axi_write(8'h08, 32'h0, 4'h1);
      clr_mon();
      axi_write(8'h00, 32'h1, 4'h1);
      wait_idle();
      chk("busy_len_div0", 32'(load_fall_cyc - (last_start_h + 1)), 32'd129);
      chk("clk_rises0", 32'(rx_bits), 32'd64);
      if (rx_q.size() > 0) chk("first_word0", 32'(rx_q[0]), 32'h0F00);

      // byte strobes, unmapped addresses, DONE clear
      axi_write(8'h10, 32'h1234, 4'h3);
      axi_write(8'h10, 32'hFFFF, 4'h1);
      axi_read(8'h10, r); chk("strb_lit", r, 32'h12FF);
      axi_read(8'h40, r); chk("unmapped_rdata_lit", r, 32'h0);
      axi_read(8'h0C, r);
      axi_write(8'h40, 32'hFFFF_FFFF, 4'hF);
      axi_read(8'h08, r); chk("clkdiv_kept_lit", r, 32'h0);
      axi_write(8'h04, 32'h2, 4'h1);
      axi_read(8'h04, r); chk("status_clr_lit", r, 32'h0);

      // reset in the middle of a transfer
      axi_write(8'h08, 32'h2, 4'h1);
      clr_mon();
      axi_write(8'h00, 32'h1, 4'h1);
      repeat (30) tick();
      do_reset();
      repeat (20) tick();
      chk("no_load_after_abort", 32'(load_cnt), 32'd0);
      axi_read(8'h04, r); chk("status_abort_lit", r, 32'h0);
      axi_read(8'h08, r); chk("clkdiv_abort_lit", r, 32'h4);
      axi_read(8'h10, r);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
